seg7_scan_capture: RTL

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

---
 rtl/seg7_scan_capture.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed active-low 7-segment display scan and rebuilds the four BCD digits.
// A pattern is only acted on once it has been sampled STABLE_CYCLES times in a row.
module seg7_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] S,
    input  logic [6:0] Y,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] valid,
    output logic [3:0] blank,
    output logic       err,
    output logic       frame_done
);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 2);

    logic [3:0]       s_q;
    logic [6:0]       y_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic [3:0]       valid_q, valid_d, blank_q, blank_d, mask_q, mask_d;
    logic             err_q, err_d, fd_q, fd_d;

    logic             diff, one_hot, code_ok;
    logic [3:0]       sel, seen;
    logic [1:0]       k;
    logic [3:0]       code_val;

    // The counter is cleared on the edge that loads a new pattern, so the
    // accept strobe fires on the STABLE_CYCLES-th consecutive identical sample.
    assign diff  = {S, Y} != {s_q, y_q};
    assign cnt_d = diff ? 8'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1);
    assign acc_d = !diff && (cnt_q == CNT_ACC);

    assign sel     = ~s_q;
    assign one_hot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);

    always_comb begin
        k = 2'd0;
        for (int i = 0; i < 4; i++)
            if (sel[i]) k = 2'(i);
    end

    always_comb begin
        code_ok  = 1'b1;
        code_val = 4'd0;
        case (y_q)
            7'b0000001: code_val = 4'd0;
            7'b1001111: code_val = 4'd1;
            7'b0010010: code_val = 4'd2;
            7'b0000110: code_val = 4'd3;
            7'b1001100: code_val = 4'd4;
            7'b0100100: code_val = 4'd5;
            7'b0100000: code_val = 4'd6;
            7'b0001111: code_val = 4'd7;
            7'b0000000: code_val = 4'd8;
            7'b0000100: code_val = 4'd9;
            default:    code_ok  = 1'b0;
        endcase
    end

    always_comb begin
        dig_d   = dig_q;
        valid_d = valid_q;
        blank_d = blank_q;
        mask_d  = mask_q;
        err_d   = 1'b0;
        fd_d    = 1'b0;
        seen    = mask_q;
        if (acc_q) begin
            if (one_hot) begin
                if (code_ok) begin
                    dig_d[k]   = code_val;
                    valid_d[k] = 1'b1;
                    blank_d[k] = 1'b0;
                end else if (y_q == 7'h7f) begin
                    blank_d[k] = 1'b1;
                    valid_d[k] = 1'b0;
                end else begin
                    err_d      = 1'b1;
                    valid_d[k] = 1'b0;
                    blank_d[k] = 1'b0;
                end
                // A repeated digit means a new scan started; restart the mask there.
                seen = ((mask_q & sel) != 4'd0) ? sel : (mask_q | sel);
                if (seen == 4'hf) begin
                    fd_d   = 1'b1;
                    mask_d = 4'd0;
                end else begin
                    mask_d = seen;
                end
            end else if (sel != 4'd0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= 4'hf;
            y_q     <= 7'h7f;
            cnt_q   <= 8'd0;
            acc_q   <= 1'b0;
            dig_q   <= '0;
            valid_q <= 4'd0;
            blank_q <= 4'd0;
            mask_q  <= 4'd0;
            err_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            s_q     <= S;
            y_q     <= Y;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dig_q   <= dig_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            fd_q    <= fd_d;
        end
    end

    assign digit0     = dig_q[0];
    assign digit1     = dig_q[1];
    assign digit2     = dig_q[2];
    assign digit3     = dig_q[3];
    assign valid      = valid_q;
    assign blank      = blank_q;
    assign err        = err_q;
    assign frame_done = fd_q;
endmodule
